main_bus_arbiter: RTL

MAIN_BUS_ARBITER -- requirements
Module: main_bus_arbiter

---
 rtl/mcDefs.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/main_bus_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mcDefs.sv
// Shared main-bus definitions: bus geometry and the arbiter state encoding.
package mcDefs;

    localparam int BUSWIDTH        = 32;
    localparam int DATAPAYLOADSIZE = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        DATA    = 2'd2,
        TURN    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot winner searching upward from
// the slot after the last granted master, wrapping to 0.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         win
);

    localparam int PW = $clog2(NREQ);

    logic [31:0]   base;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        base  = 32'(last);
        idx   = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = PW'((base + off) % NREQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/main_bus_arbiter.sv
// Round-robin owner arbitration for main_bus_if; observes AddrValid/rw only and
// tracks each transfer through address, data beats and a one-cycle turnaround.
module main_bus_arbiter
    import mcDefs::*;
#(
    parameter int NREQ        = 2,
    parameter int BURST       = DATAPAYLOADSIZE,
    parameter int GNT_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            resetH,
    input  logic [NREQ-1:0] req,
    input  logic            AddrValid,
    input  logic            rw,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            xfer_rw,
    output logic            xfer_done,
    output logic            proto_err
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(BURST) + 1;
    localparam int TW = $clog2(GNT_TIMEOUT) + 1;

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            busy_q, busy_d;
    logic            xrw_q, xrw_d;
    logic            done_q, done_d;
    logic            perr_q, perr_d;

    logic [NREQ-1:0] win;
    logic [PW-1:0]   win_idx;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req  (req),
        .last (ptr_q),
        .win  (win)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win[i]) win_idx = PW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        tmr_d   = tmr_q;
        xrw_d   = xrw_q;
        perr_d  = perr_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANTED;
                    grant_d = win;
                    ptr_d   = win_idx;
                    tmr_d   = '0;
                end
            end
            GRANTED: begin
                if (AddrValid) begin
                    xrw_d   = rw;
                    beat_d  = '0;
                    state_d = DATA;
                end else if (!(|(req & grant_q)) || (tmr_q == TW'(GNT_TIMEOUT - 1))) begin
                    state_d = TURN;
                    grant_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DATA: begin
                if (beat_q == BW'(BURST - 1)) begin
                    state_d = TURN;
                    grant_d = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        if (AddrValid && (state_q != GRANTED)) perr_d = 1'b1;
        // Outputs are registered, so the last-beat pulse is decided from next state.
        done_d = (state_d == DATA) && (beat_d == BW'(BURST - 1));
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (resetH) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(NREQ - 1);
            beat_q  <= '0;
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            xrw_q   <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            tmr_q   <= tmr_d;
            busy_q  <= busy_d;
            xrw_q   <= xrw_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign xfer_rw   = xrw_q;
    assign xfer_done = done_q;
    assign proto_err = perr_q;

endmodule
